// File: rtl/aibcr3_dcc_crsgryctrl_if.sv
// rtl/aibcr3_dcc_crsgryctrl_if.sv - phase-decision inputs and coarse-code status outputs of the DCC coarse Gray controller
interface aibcr3_dcc_crsgryctrl_if;
  logic        EN;
  logic        PD_VLD;
  logic        PD_UP;
  logic [10:3] gry;
  logic        LOCK;
  logic        SATMAX;
  logic        SATMIN;
  logic        BUSY;

  modport master (
    output EN, PD_VLD, PD_UP,
    input  gry, LOCK, SATMAX, SATMIN, BUSY
  );

  modport slave (
    input  EN, PD_VLD, PD_UP,
    output gry, LOCK, SATMAX, SATMIN, BUSY
  );
endinterface

// File: rtl/aibcr3_dcc_crsgryctrl.sv
// rtl/aibcr3_dcc_crsgryctrl.sv - DCC coarse delay search: settle/sample stepping of a Gray-coded code with reversal lock
module aibcr3_dcc_crsgryctrl #(
  parameter int          SETTLE_CYC = 8,
  parameter int          LOCK_REV   = 4,
  parameter logic [7:0]  INIT_CODE  = 8'd0
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  aibcr3_dcc_crsgryctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LD  = 4'(SETTLE_CYC - 1);
  localparam logic [2:0] LOCK_REV_C = 3'(LOCK_REV);

  function automatic logic [7:0] to_gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  state_t      state_q;
  logic [7:0]  bin_q;
  logic [10:3] gry_q;
  logic [3:0]  cnt_q;
  logic [2:0]  rev_q;
  logic        dir_q;
  logic        dir_vld_q;
  logic        lock_q;
  logic        satmax_q;
  logic        satmin_q;
  logic        busy_q;

  logic [2:0]  rev_d;
  logic [7:0]  bin_d;
  logic        sat_hit;
  logic        lock_hit;

  // Decision evaluation; a saturated request still counts as a direction sample.
  always_comb begin
    rev_d    = 3'd0;
    sat_hit  = 1'b0;
    bin_d    = bin_q;
    lock_hit = 1'b0;
    if (dir_vld_q && (bus.PD_UP != dir_q)) begin
      rev_d = rev_q + 3'd1;
    end
    sat_hit = bus.PD_UP ? (bin_q == 8'hFF) : (bin_q == 8'h00);
    if (!sat_hit) begin
      bin_d = bus.PD_UP ? (bin_q + 8'd1) : (bin_q - 8'd1);
    end
    lock_hit = (rev_d == LOCK_REV_C);
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state_q   <= ST_IDLE;
      bin_q     <= INIT_CODE;
      gry_q     <= to_gray(INIT_CODE);
      cnt_q     <= 4'd0;
      rev_q     <= 3'd0;
      dir_q     <= 1'b0;
      dir_vld_q <= 1'b0;
      lock_q    <= 1'b0;
      satmax_q  <= 1'b0;
      satmin_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else if (!bus.EN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      rev_q     <= 3'd0;
      dir_vld_q <= 1'b0;
      lock_q    <= 1'b0;
      satmax_q  <= 1'b0;
      satmin_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_SETTLE;
          cnt_q   <= SETTLE_LD;
          busy_q  <= 1'b1;
        end
        ST_SETTLE: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (bus.PD_VLD) begin
            rev_q     <= rev_d;
            dir_q     <= bus.PD_UP;
            dir_vld_q <= 1'b1;
            bin_q     <= bin_d;
            gry_q     <= to_gray(bin_d);
            if (sat_hit) begin
              if (bus.PD_UP) satmax_q <= 1'b1;
              else           satmin_q <= 1'b1;
            end else begin
              if (bus.PD_UP) satmin_q <= 1'b0;
              else           satmax_q <= 1'b0;
            end
            // The locking decision's step lands on the same edge as LOCK.
            if (lock_hit) begin
              state_q <= ST_LOCKED;
              lock_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (!sat_hit) begin
              state_q <= ST_SETTLE;
              cnt_q   <= SETTLE_LD;
            end
          end
        end
        default: begin
          state_q <= ST_LOCKED;
        end
      endcase
    end
  end

  assign bus.gry    = gry_q;
  assign bus.LOCK   = lock_q;
  assign bus.SATMAX = satmax_q;
  assign bus.SATMIN = satmin_q;
  assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_aibcr3_dcc_crsgryctrl.sv
// tb/tb_aibcr3_dcc_crsgryctrl.sv - self-checking bench for aibcr3_dcc_crsgryctrl
module tb_aibcr3_dcc_crsgryctrl;

  localparam int SETTLE_CYC = 8;
  localparam int LOCK_REV   = 4;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  aibcr3_dcc_crsgryctrl_if bus ();

  aibcr3_dcc_crsgryctrl #(
    .SETTLE_CYC (SETTLE_CYC),
    .LOCK_REV   (LOCK_REV),
    .INIT_CODE  (8'd0)
  ) dut (
    .CLK  (clk),
    .RSTb (rstb),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the code as an integer plus the search's observable flags.
  int m_bin;
  bit m_have, m_last, m_lock, m_satmax, m_satmin, m_busy;
  int m_rev;

  typedef struct {
    bit         up;
    logic [7:0] gry;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [7:0] gray(input int b);
    logic [7:0] v;
    v = b[7:0];
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_state(input string nm);
    chk(nm, {bus.gry, bus.LOCK, bus.SATMAX, bus.SATMIN, bus.BUSY},
        {gray(m_bin), m_lock, m_satmax, m_satmin, m_busy});
  endtask

  task automatic model_idle();
    m_have = 0; m_rev = 0; m_lock = 0; m_satmax = 0; m_satmin = 0; m_busy = 0;
  endtask

  task automatic model_reset();
    model_idle();
    m_bin = 0; m_last = 0;
  endtask

  task automatic model_decide(input bit up, output bit stepped);
    stepped = 0;
    if (m_lock) return;
    if (m_have && up != m_last) m_rev++;
    else                        m_rev = 0;
    m_have = 1;
    m_last = up;
    if (up) begin
      if (m_bin == 255) m_satmax = 1;
      else begin m_bin++; m_satmin = 0; stepped = 1; end
    end else begin
      if (m_bin == 0) m_satmin = 1;
      else begin m_bin--; m_satmax = 0; stepped = 1; end
    end
    if (m_rev == LOCK_REV) begin
      m_lock = 1;
      m_busy = 0;
    end
  endtask

  // Called just after the edge that entered SETTLE; the probe lands on the last SETTLE edge.
  task automatic settle_wait(input bit probe, input bit pup);
    repeat (SETTLE_CYC - 1) tick();
    bus.PD_VLD = probe;
    bus.PD_UP  = pup;
    tick();
    bus.PD_VLD = 1'b0;
    check_state("settle_probe_ignored");
  endtask

  task automatic decide(input bit up, input string nm);
    bit stepped;
    bus.PD_VLD = 1'b1;
    bus.PD_UP  = up;
    tick();
    bus.PD_VLD = 1'b0;
    model_decide(up, stepped);
    check_state(nm);
    if (stepped && !m_lock) settle_wait(1'($urandom % 2), 1'($urandom % 2));
  endtask

  task automatic enable();
    bus.EN = 1'b1;
    tick();
    m_busy = 1;
    check_state("enable_busy");
    settle_wait(1'b1, 1'($urandom % 2));
  endtask

  task automatic disable_en();
    bus.EN = 1'b0;
    tick();
    model_idle();
    check_state("disable_idle");
  endtask

  task automatic goto_code(input int target);
    while (m_bin != target && !m_lock) decide(m_bin < target, "goto");
  endtask

  initial begin
    logic [7:0] prev;
    tbl[0] = '{1'b1, 8'h01}; tbl[1] = '{1'b1, 8'h03}; tbl[2] = '{1'b1, 8'h02};
    tbl[3] = '{1'b1, 8'h06}; tbl[4] = '{1'b1, 8'h07}; tbl[5] = '{1'b1, 8'h05};
    tbl[6] = '{1'b1, 8'h04}; tbl[7] = '{1'b1, 8'h0C}; tbl[8] = '{1'b1, 8'h0D};
    tbl[9] = '{1'b1, 8'h0F};

    rstb = 1'b0;
    bus.EN = 1'b1;
    bus.PD_VLD = 1'b0;
    bus.PD_UP = 1'b0;
    tick();
    tick();
    model_reset();
    check_state("reset_values");
    chk("reset_gry", {4'h0, bus.gry}, 12'h000);

    rstb = 1'b1;
    tick();
    m_busy = 1;
    check_state("busy_after_release");
    settle_wait(1'b1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      prev = bus.gry;
      decide(tbl[i].up, "ramp_state");
      chk("ramp_gry", {4'h0, bus.gry}, {4'h0, tbl[i].gry});
      chk("ramp_one_bit", 12'($countones(prev ^ bus.gry)), 12'd1);
    end

    for (int i = 0; i < 80; i++) begin
      if (m_lock) begin
        decide(1'($urandom % 2), "locked_ignores_vld");
        disable_en();
        enable();
      end else begin
        decide(1'($urandom % 2), "random_decision");
      end
    end
    if (m_lock) begin
      disable_en();
      enable();
    end

    prev = bus.gry;
    bus.EN = 1'b0;
    bus.PD_VLD = 1'b1;
    bus.PD_UP = 1'($urandom % 2);
    tick();
    bus.PD_VLD = 1'b0;
    model_idle();
    check_state("en_drop_with_vld");
    chk("en_drop_no_step", {4'h0, bus.gry}, {4'h0, prev});

    enable();
    goto_code(99);
    disable_en();
    enable();
    decide(1'b1, "alt1");
    decide(1'b0, "alt2");
    decide(1'b1, "alt3");
    decide(1'b0, "alt4");
    decide(1'b1, "alt5_lock");
    chk("lock_flags", {9'h0, bus.LOCK, bus.BUSY, 1'b0}, {9'h0, 1'b1, 1'b0, 1'b0});
    chk("lock_gry", {4'h0, bus.gry}, 12'h056);
    for (int i = 0; i < 3; i++) decide(1'($urandom % 2), "locked_frozen");
    chk("locked_gry_frozen", {4'h0, bus.gry}, 12'h056);

    rstb = 1'b0;
    tick();
    model_reset();
    check_state("reset_in_locked");
    rstb = 1'b1;
    tick();
    m_busy = 1;
    check_state("reenter_settle");
    settle_wait(1'b1, 1'b1);

    decide(1'b0, "satmin_set");
    chk("satmin_flag", {11'h0, bus.SATMIN}, 12'h001);
    decide(1'b1, "satmin_clear");

    goto_code(255);
    decide(1'b1, "satmax_set");
    decide(1'b1, "satmax_hold");
    chk("satmax_gry", {3'h0, bus.SATMAX, bus.gry}, 12'h180);
    decide(1'b0, "satmax_clear");
    chk("unsat_gry", {3'h0, bus.SATMAX, bus.gry}, 12'h081);

    disable_en();
    bus.EN = 1'b1;
    tick();
    repeat (3) tick();
    rstb = 1'b0;
    tick();
    model_reset();
    check_state("reset_mid_settle");
    rstb = 1'b1;
    tick();
    m_busy = 1;
    check_state("resettle_after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
